// File: rtl/pool_ctrl.sv
// Pacing and control stage ahead of the 2x2 max-pool datapath: pairs pixels, drives row phase,
// line-FIFO enables, pooled-output valid and end of frame. Optional macro: POOL_CTRL_SOF_CHECK_EN.
module pool_ctrl #(
    parameter int DW    = 8,
    parameter int IMG_W = 26,
    parameter int IMG_H = 26,
    parameter int CNT_W = 5
) (
    input  logic          sclk,
    input  logic          s_rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_data,
    input  logic          in_sof,
    output logic          pool_stride,
    output logic          pool_data_vld,
    output logic [DW-1:0] pool_data,
    output logic [3:0]    row_cnt,
    output logic          fifo_wr_en,
    output logic          fifo_rd_en,
    output logic          pool_out_vld,
    output logic          frame_done,
    output logic          sof_err
);

    typedef enum logic [1:0] {
        WAIT_EVEN = 2'd0,
        HAVE_EVEN = 2'd1,
        EMIT_ODD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic [DW-1:0]    r_even;
    logic [DW-1:0]    r_odd;
    logic             r_rdy;
    logic             r_stride;
    logic             r_dvld;
    logic [DW-1:0]    r_pdata;
    logic [3:0]       r_row_cnt;
    logic             r_wr;
    logic             r_rd;
    logic             r_ovld;
    logic             r_done;
    logic             r_sof_err;
    logic             r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;
    logic             r_par_p0, r_par_p1, r_par_p2;
    logic             r_last_p0, r_last_p1, r_last_p2, r_last_p3;

    logic w_acc;
    logic w_resync;
    logic w_keep;
    logic w_odd_acc;
    logic w_col_wrap;
    logic w_row_last;

    assign w_acc      = in_vld && r_rdy;
    assign w_col_wrap = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

`ifdef POOL_CTRL_SOF_CHECK_EN
    assign w_resync = w_acc && in_sof && ((r_col != '0) || (r_row != '0));
`else
    // Framing marker is deliberately ignored in this build.
    assign w_resync = 1'b0 & in_sof;
`endif

    assign w_keep    = !w_resync;
    assign w_odd_acc = w_acc && (r_state == HAVE_EVEN) && w_keep;

    always_ff @(posedge sclk) begin
        if (w_acc && ((r_state == WAIT_EVEN) || w_resync)) r_even <= in_data;
        if (w_odd_acc) r_odd <= in_data;
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            r_state   <= WAIT_EVEN;
            r_col     <= '0;
            r_row     <= '0;
            r_rdy     <= 1'b1;
            r_stride  <= 1'b1;
            r_dvld    <= 1'b0;
            r_pdata   <= '0;
            r_row_cnt <= '0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_ovld    <= 1'b0;
            r_done    <= 1'b0;
            r_sof_err <= 1'b0;
            r_vld_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_vld_p3  <= 1'b0;
            r_par_p0  <= 1'b0;
            r_par_p1  <= 1'b0;
            r_par_p2  <= 1'b0;
            r_last_p0 <= 1'b0;
            r_last_p1 <= 1'b0;
            r_last_p2 <= 1'b0;
            r_last_p3 <= 1'b0;
        end else begin
            case (r_state)
                WAIT_EVEN: if (w_acc) r_state <= HAVE_EVEN;
                HAVE_EVEN: if (w_odd_acc) r_state <= EMIT_ODD;
                default:   r_state <= WAIT_EVEN;
            endcase
            r_rdy    <= !w_odd_acc;
            r_stride <= 1'b1;

            if (w_resync) begin
                r_col <= CNT_W'(1);
                r_row <= '0;
            end else if (w_acc) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + CNT_W'(1);
                end else begin
                    r_col <= r_col + CNT_W'(1);
                end
            end
            if (w_resync) r_sof_err <= 1'b1;

            // p0: pair captured, even half on the output
            r_vld_p0  <= w_odd_acc;
            r_par_p0  <= r_row[0];
            r_last_p0 <= w_row_last && w_col_wrap;
            if (w_odd_acc) r_row_cnt <= {3'b000, r_row[0]};

            // p1: odd half on the output, odd rows fetch the line-FIFO word
            r_vld_p1  <= r_vld_p0 && w_keep;
            r_par_p1  <= r_par_p0;
            r_last_p1 <= r_last_p0;
            r_dvld    <= w_odd_acc || (r_vld_p0 && w_keep);
            r_pdata   <= w_odd_acc ? r_even : ((r_vld_p0 && w_keep) ? r_odd : '0);
            r_rd      <= r_vld_p0 && r_par_p0 && w_keep;

            // p2: even rows store the pair max
            r_vld_p2  <= r_vld_p1 && w_keep;
            r_par_p2  <= r_par_p1;
            r_last_p2 <= r_last_p1;
            r_wr      <= r_vld_p1 && !r_par_p1 && w_keep;

            // p3: pooled result valid; one cycle later the frame closes
            r_vld_p3  <= r_vld_p2 && w_keep;
            r_last_p3 <= r_last_p2;
            r_ovld    <= r_vld_p2 && r_par_p2 && w_keep;
            r_done    <= r_vld_p3 && r_last_p3 && w_keep;
        end
    end

    assign in_rdy        = r_rdy;
    assign pool_stride   = r_stride;
    assign pool_data_vld = r_dvld;
    assign pool_data     = r_pdata;
    assign row_cnt       = r_row_cnt;
    assign fifo_wr_en    = r_wr;
    assign fifo_rd_en    = r_rd;
    assign pool_out_vld  = r_ovld;
    assign frame_done    = r_done;
    assign sof_err       = r_sof_err;

endmodule

// File: tb/tb_pool_ctrl.sv
// Bench for pool_ctrl on a 4x4 map: per-cycle comparison against a schedule computed from pixel
// positions, plus a small datapath model (pair max + line FIFO) producing the pooled values.
module tb_pool_ctrl;
    localparam int DW = 8, IMG_W = 4, IMG_H = 4, CNT_W = 2, MAXC = 8192;

    logic sclk = 1'b0, s_rst = 1'b1, in_vld = 1'b0, in_sof = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_rdy, pool_stride, pool_data_vld, fifo_wr_en, fifo_rd_en;
    logic pool_out_vld, frame_done, sof_err;
    logic [DW-1:0] pool_data;
    logic [3:0] row_cnt;

    pool_ctrl #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)) dut (
        .sclk(sclk), .s_rst(s_rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_sof(in_sof), .pool_stride(pool_stride), .pool_data_vld(pool_data_vld),
        .pool_data(pool_data), .row_cnt(row_cnt), .fifo_wr_en(fifo_wr_en),
        .fifo_rd_en(fifo_rd_en), .pool_out_vld(pool_out_vld), .frame_done(frame_done),
        .sof_err(sof_err)
    );

    always #5 sclk = ~sclk;

    int checks = 0, errors = 0;
    // exp_*[k]: expected output during the cycle that follows clock edge k
    int exp_rdy[MAXC], exp_dvld[MAXC], exp_data[MAXC], exp_rowset[MAXC], exp_rd[MAXC];
    int exp_wr[MAXC], exp_ovld[MAXC], exp_done[MAXC], exp_pool[MAXC], exp_sof[MAXC];
    int e = -1, pos = 0, even_v = 0, m_sof = 0, cur_row = 0;
    int rowmax[IMG_W/2];
    int dp_first = 0, dp_half = 0, dp_pm = 0, dp_rd = 0;
    int dp_q[$];
    int got[$];
    int cnt_ovld = 0, cnt_done = 0, sof_mode = 0;
    int stim[64];

    task automatic chk(input string nm, input int act, input int ex);
        checks++;
        if (act != ex) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, ex);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic clr(input int k);
        exp_rdy[k] = 1; exp_dvld[k] = 0; exp_data[k] = 0; exp_rowset[k] = -1; exp_rd[k] = 0;
        exp_wr[k] = 0; exp_ovld[k] = 0; exp_done[k] = 0; exp_pool[k] = 0;
    endtask

    // Reference: each accepted pixel's raster position decides the whole pair schedule.
    always @(posedge sclk) begin
        int col, row, acc, pm;
        e = e + 1;
        if (e + 8 >= MAXC) begin
            $display("FAIL cycle_budget t=%0t got=%0d expected=<%0d", $time, e, MAXC - 8);
            $fatal(1, "cycle budget exhausted");
        end
        if (s_rst) begin
            for (int k = 0; k < 7; k++) clr(e + k);
            exp_rowset[e] = 0;
            pos = 0;
            m_sof = 0;
        end else begin
            acc = (e > 0 && in_vld && exp_rdy[e-1] != 0) ? 1 : 0;
            if (acc != 0) begin
`ifdef POOL_CTRL_SOF_CHECK_EN
                if (in_sof && pos != 0) begin
                    m_sof = 1;
                    pos = 0;
                    for (int k = 0; k < 6; k++) clr(e + k);
                end
`endif
                col = pos % IMG_W;
                row = pos / IMG_W;
                if (col % 2 == 0) begin
                    even_v = int'(in_data);
                end else begin
                    pm = imax(even_v, int'(in_data));
                    exp_rdy[e] = 0;
                    exp_dvld[e] = 1;     exp_data[e] = even_v;
                    exp_dvld[e+1] = 1;   exp_data[e+1] = int'(in_data);
                    exp_rowset[e] = row % 2;
                    if (row % 2 == 0) begin
                        exp_wr[e+2] = 1;
                        rowmax[col/2] = pm;
                    end else begin
                        exp_rd[e+1] = 1;
                        exp_ovld[e+3] = 1;
                        exp_pool[e+3] = imax(rowmax[col/2], pm);
                    end
                    if (row == IMG_H - 1 && col == IMG_W - 1) exp_done[e+4] = 1;
                end
                pos = (pos + 1) % (IMG_W * IMG_H);
            end
        end
        exp_sof[e] = m_sof;
    end

    // Compare every cycle, then feed the outputs through the datapath model.
    always @(negedge sclk) begin
        int k, v;
        if (e >= 0) begin
            k = e;
            if (exp_rowset[k] >= 0) cur_row = exp_rowset[k];
            chk("in_rdy", int'(in_rdy), exp_rdy[k]);
            chk("pool_stride", int'(pool_stride), 1);
            chk("pool_data_vld", int'(pool_data_vld), exp_dvld[k]);
            chk("pool_data", int'(pool_data), exp_data[k]);
            chk("row_cnt", int'(row_cnt), cur_row);
            chk("fifo_rd_en", int'(fifo_rd_en), exp_rd[k]);
            chk("fifo_wr_en", int'(fifo_wr_en), exp_wr[k]);
            chk("pool_out_vld", int'(pool_out_vld), exp_ovld[k]);
            chk("frame_done", int'(frame_done), exp_done[k]);
            chk("sof_err", int'(sof_err), exp_sof[k]);

            if (pool_data_vld) begin
                if (dp_half == 0) begin
                    dp_first = int'(pool_data);
                    dp_half = 1;
                end else begin
                    dp_pm = imax(dp_first, int'(pool_data));
                    dp_half = 0;
                end
            end
            if (fifo_rd_en) begin
                chk("fifo_read_nonempty", (dp_q.size() > 0) ? 1 : 0, 1);
                if (dp_q.size() > 0) dp_rd = dp_q.pop_front();
            end
            if (fifo_wr_en) begin
                dp_q.push_back(dp_pm);
                if (sof_mode == 0) chk("fifo_occupancy_le_half_width", (dp_q.size() <= IMG_W/2) ? 1 : 0, 1);
            end
            if (pool_out_vld) begin
                v = imax(dp_pm, dp_rd);
                got.push_back(v);
                cnt_ovld++;
                if (sof_mode == 0 && exp_ovld[k] != 0) chk("pooled_value", v, exp_pool[k]);
            end
            if (frame_done) cnt_done++;
            if (s_rst) begin
                dp_q.delete();
                dp_half = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // mode 0: in_vld always 1, 1: toggling every cycle, 2: random stalls
    task automatic stream(input int n, input int mode, input int sof_idx);
        int i, t, v, r, tog;
        i = 0; t = 0; tog = 1;
        while (i < n && t < 2000) begin
            v = (mode == 0) ? 1 : (mode == 1) ? tog : (($urandom_range(0, 3) != 0) ? 1 : 0);
            in_vld = (v != 0);
            in_data = DW'(stim[i]);
            in_sof = (i == sof_idx);
            @(negedge sclk);
            r = int'(in_rdy);
            @(posedge sclk);
            #1;
            if (v != 0 && r != 0) i++;
            tog = 1 - tog;
            t++;
        end
        in_vld = 1'b0;
        in_sof = 1'b0;
        in_data = '0;
        chk("stream_accepted_all", i, n);
    endtask

    task automatic check_out(input string nm, input int a0, input int a1, input int a2, input int a3);
        int ref_v[4];
        ref_v = '{a0, a1, a2, a3};
        chk({nm, "_count"}, got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk(nm, got[i], ref_v[i]);
    endtask

    initial begin
        int o, d;
        for (int k = 0; k < MAXC; k++) begin
            clr(k);
            exp_sof[k] = 0;
        end
        repeat (3) @(posedge sclk);
        #1;
        s_rst = 1'b0;
        chk("rst_in_rdy", int'(in_rdy), 1);
        chk("rst_pool_stride", int'(pool_stride), 1);
        chk("rst_pool_data_vld", int'(pool_data_vld), 0);
        chk("rst_row_cnt", int'(row_cnt), 0);
        chk("rst_pool_out_vld", int'(pool_out_vld), 0);

        // Ascending frame, in_vld held high
        for (int i = 0; i < 16; i++) stim[i] = i;
        got.delete(); d = cnt_done;
        stream(16, 0, -1);
        idle(10);
        check_out("ascending_full_rate", 5, 7, 13, 15);
        chk("ascending_full_rate_frame_done", cnt_done - d, 1);

        // Same frame, in_vld toggling
        got.delete(); d = cnt_done;
        stream(16, 1, -1);
        idle(10);
        check_out("ascending_toggle", 5, 7, 13, 15);
        chk("ascending_toggle_frame_done", cnt_done - d, 1);

        // Three random frames with random stalls
        for (int i = 0; i < 48; i++) stim[i] = int'($urandom_range(0, 255));
        o = cnt_ovld; d = cnt_done;
        stream(48, 2, -1);
        idle(10);
        chk("random_pool_out_count", cnt_ovld - o, 12);
        chk("random_frame_done_count", cnt_done - d, 3);

        // Two back-to-back frames at full rate
        for (int i = 0; i < 32; i++) stim[i] = int'($urandom_range(0, 255));
        o = cnt_ovld; d = cnt_done;
        stream(32, 0, -1);
        idle(10);
        chk("back_to_back_pool_out_count", cnt_ovld - o, 8);
        chk("back_to_back_frame_done_count", cnt_done - d, 2);

        // Abort mid row 1, then a descending frame
        for (int i = 0; i < 16; i++) stim[i] = i;
        got.delete(); d = cnt_done;
        stream(6, 0, -1);
        s_rst = 1'b1;
        @(posedge sclk);
        #1;
        s_rst = 1'b0;
        for (int i = 0; i < 16; i++) stim[i] = 15 - i;
        stream(16, 0, -1);
        idle(10);
        check_out("after_reset_descending", 15, 13, 7, 5);
        chk("after_reset_frame_done", cnt_done - d, 1);

`ifdef POOL_CTRL_SOF_CHECK_EN
        for (int i = 0; i < 21; i++) stim[i] = i;
        sof_mode = 1;
        o = cnt_ovld; d = cnt_done;
        stream(21, 0, 5);
        idle(10);
        chk("sof_err_raised", int'(sof_err), 1);
        chk("resync_pool_out_count", cnt_ovld - o, 4);
        chk("resync_frame_done_count", cnt_done - d, 1);
        idle(5);
        chk("sof_err_sticky", int'(sof_err), 1);
`else
        for (int i = 0; i < 16; i++) stim[i] = i;
        got.delete(); d = cnt_done;
        stream(16, 0, 5);
        idle(10);
        check_out("sof_ignored", 5, 7, 13, 15);
        chk("sof_ignored_frame_done", cnt_done - d, 1);
        chk("sof_err_tied_low", int'(sof_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pool_ctrl.md
Name: pool_ctrl

Overview:
- Control and pacing stage directly upstream of the 2x2 max-pool datapath (pair-max register plus line FIFO).
- Accepts a raster-order conv feature-map stream through a valid/ready handshake and re-times each horizontal pixel pair so it reaches the datapath on back-to-back cycles.
- Generates the datapath's row-phase, FIFO write/read enables and an output-valid flag aligned with the pooled result.
- Signals end of frame.

Parameters:
- DW, 8, pixel width.
- IMG_W, 26, feature-map width in pixels; must be even and ≥2.
- IMG_H, 26, feature-map height in rows; must be even and ≥2.
- CNT_W, 5, width of the column and row counters; must satisfy 2^CNT_W ≥ max(IMG_W, IMG_H).

Ports:
- sclk  input  1  clock.
- s_rst  input  1  reset, synchronous, active-high.
- in_vld  input  1  upstream pixel valid.
- in_rdy  output  1  block can accept a pixel.
- in_data  input  DW  upstream pixel.
- in_sof  input  1  marks the first pixel of a frame (used only with the optional feature).
- pool_stride  output  1  to datapath; constant 1 (2x2, stride 2).
- pool_data_vld  output  1  to datapath data_in_vld.
- pool_data  output  DW  to datapath data_in.
- row_cnt  output  4  to datapath; pooling-window row phase, 0 or 1; upper bits are 0.
- fifo_wr_en  output  1  line-FIFO write enable.
- fifo_rd_en  output  1  line-FIFO read enable (read data appears one cycle later).
- pool_out_vld  output  1  datapath data_out holds a valid pooled pixel this cycle.
- frame_done  output  1  one-cycle pulse after the last pooled pixel of the frame.
- sof_err  output  1  sticky framing error (optional feature only).

Behaviour:
- Reset (s_rst=1 at a clock edge):
  - Every output register goes to 0, except in_rdy=1 and pool_stride=1.
  - State → WAIT_EVEN; col and row counters → 0.
  - Reset mid-frame abandons the frame. No pool_out_vld or frame_done is issued for it.
- Handshake: a pixel transfers when in_vld && in_rdy at a clock edge. in_rdy = (state != EMIT_ODD).
- State machine:
  - WAIT_EVEN: accepted pixel is stored in even_reg; next state HAVE_EVEN.
  - HAVE_EVEN: accepted pixel is stored in odd_reg; next state EMIT_ODD.
  - EMIT_ODD: no pixel is accepted; next state WAIT_EVEN.
  - No accept means the state holds. Upstream may stall between any pixels.
- Pair timing, with the odd pixel accepted at edge c:
  - Cycle c+1: pool_data=even_reg, pool_data_vld=1.
  - Cycle c+2: pool_data=odd_reg, pool_data_vld=1.
  - All other cycles: pool_data_vld=0 and pool_data=0.
  - The two halves of a pair are never separated by a gap.
- row_cnt:
  - Equals row[0] of the pair, registered with pool_data.
  - Held between pairs and changes only at c+1 of the next pair.
- Enables for the pair at row r:
  - r even: fifo_wr_en=1 at cycle c+3 only.
  - r odd: fifo_rd_en=1 at cycle c+2, pool_out_vld=1 at cycle c+4.
- Throughput: maximum 2 pixels per 3 cycles. Schedules of consecutive pairs never overlap, because the next odd accept is at c+3 or later.
- Counters:
  - col advances on each accept and wraps from IMG_W-1 to 0.
  - On that wrap, row increments and wraps from IMG_H-1 to 0.
- FIFO occupancy:
  - Peaks at IMG_W/2 entries after an even row.
  - Returns to 0 after the following odd row.
  - The block never writes when the FIFO holds IMG_W/2 entries and never reads when it is empty.
- frame_done: pulses at c+5 of the pair that completes row IMG_H-1. The next frame may start immediately.
- Outputs per frame: exactly (IMG_W/2)*(IMG_H/2) pool_out_vld pulses.

Optional Feature:
- Macro: POOL_CTRL_SOF_CHECK_EN.
- Defined:
  - An accepted pixel with in_sof=1 when col≠0 or row≠0 sets sof_err, which holds until reset.
  - The same event forces col and row to treat that pixel as pixel (0,0).
  - It also discards any held even_reg, and the pending schedule is cancelled.
  - Because the line FIFO cannot be flushed by this block, correct pooling after a resync requires an s_rst.
- Undefined: in_sof is ignored, sof_err is tied to 0, and counters run purely on pixel count.

Test Plan:
- IMG_W=4, IMG_H=4, in_vld always 1, pixels 0..15 through block plus datapath.
  - Required: pool_out_vld pulses exactly 4 times, with data_out = 5, 7, 13, 15.
  - Required: frame_done pulses once, one cycle after the last pool_out_vld.
- Same frame with in_vld toggling 1/0 every cycle.
  - Required: identical outputs 5, 7, 13, 15.
  - Required: pool_data_vld pairs always contiguous.
  - Required: in_rdy=0 only in EMIT_ODD cycles.
- Row-0 timing check: odd pixel accepted at edge c.
  - Required: fifo_wr_en high only at c+3.
  - Required: no fifo_rd_en and no pool_out_vld anywhere in rows 0 and 2.
- Reset pulse s_rst=1 mid-row 1, then a fresh 4x4 frame with descending pixels 15..0.
  - Required: no output for the aborted frame.
  - Required: new outputs 15, 13, 7, 5.
- Two back-to-back 4x4 frames.
  - Required: 8 pool_out_vld pulses, frame_done twice, FIFO occupancy never exceeds 2.
- With POOL_CTRL_SOF_CHECK_EN defined, in_sof=1 on pixel index 5.
  - Required: sof_err rises and stays 1.
  - Required: counters restart, so 16 further pixels yield 4 pool_out_vld pulses and frame_done.
